fetch_redirect_ctrl: RTL
========================

Name: fetch_redirect_ctrl

Overview:
- Sequencer for the M1 fetch stage.
- Drives the fetch stage's clock enable, write enable and write data, so it controls PC advance, stall and redirect.
- Arbitrates redirect sources: traps, branch resolution, interrupts and debug PC writes.
- After every redirect, issues a fixed-length flush pulse so downstream stages kill wrong-path instructions.

Parameters:
ADDR_W, 15, PC/address width (matches fetch PC).
FLUSH_CYCLES, 2, cycles flush stays high after a redirect (1..15).
TRAP_VEC, 15'h0004, trap vector base.
IRQ_VEC, 15'h0040, interrupt vector.

Ports:
clk  in  1  core clock.
async_rst_n  in  1  asynchronous active-low reset.
stall_req  in  1  downstream back-pressure; hold PC.
icache_miss  in  1  cache miss (informational; fetch stage self-holds).
fetch_pc  in  ADDR_W  current PC from fetch stage.
br_valid  in  1  branch misprediction/taken redirect.
br_target  in  ADDR_W  branch target.
trap_valid  in  1  synchronous exception.
trap_cause  in  4  exception cause.
irq_req  in  1  level interrupt request.
irq_en  in  1  global interrupt enable.
halt_req  in  1  debug halt request.
resume_req  in  1  debug resume.
dbg_pc_valid  in  1  debug PC write (HALT only).
dbg_pc  in  ADDR_W  debug PC value.
fetch_clk_en  out  1  to fetch clk_en.
fetch_write_en  out  1  to fetch write_en.
fetch_data_in  out  ADDR_W  to fetch data_in.
flush  out  1  kill younger pipeline instructions.
epc  out  ADDR_W  saved return PC (trap/irq).
irq_ack  out  1  one-cycle interrupt accept pulse.
halted  out  1  core in HALT.

Behaviour:
- Reset (async_rst_n low), all asynchronous:
  - Registered state: state=RUN, flush_cnt=0, epc=0.
  - Outputs: fetch_clk_en=0, fetch_write_en=0, fetch_data_in=0, flush=0, irq_ack=0, halted=0.
- States: RUN, FLUSH, HALT. Redirect outputs are combinational from state and inputs (0-cycle latency); the PC updates on the same clk edge.
- RUN priority (highest first):
  - trap_valid: write_en=1; data=TRAP_VEC+(trap_cause<<2), truncated mod 2^ADDR_W; epc<=fetch_pc; go to FLUSH.
  - br_valid: write_en=1; data=br_target; go to FLUSH.
  - irq_req&&irq_en: write_en=1; data=IRQ_VEC; epc<=fetch_pc; irq_ack=1; go to FLUSH.
  - halt_req: go to HALT. No write this cycle; clk_en=0.
  - else: clk_en=!stall_req.
- Any cycle with write_en=1 forces fetch_clk_en=1, so a redirect overrides stall_req.
- Whenever write_en=0, fetch_data_in=0.
- FLUSH:
  - flush=1 and clk_en=!stall_req.
  - flush_cnt loads FLUSH_CYCLES-1 on entry and decrements each cycle, independent of stall.
  - At flush_cnt==0 the next state is RUN.
  - br_valid, irq_req and halt_req are ignored (wrong path / deferred).
  - trap_valid is accepted with the same redirect and epc capture as in RUN, and reloads flush_cnt.
- HALT:
  - halted=1; clk_en=0 unless dbg_pc_valid.
  - dbg_pc_valid: write_en=1, clk_en=1, data=dbg_pc; remain in HALT.
  - resume_req (dbg_pc_valid takes priority when both are high): go to RUN.
  - All other requests are ignored.
- flush is 0 in RUN and HALT. irq_ack is 0 except in the accept cycle.
- Simultaneous trap+branch+irq: the trap wins. The branch is dropped; the irq stays pending because it is level-sensitive.
- Reset mid-FLUSH or in HALT: immediate return to RUN with all outputs at reset values.

Optional Feature:
FETCH_REDIRECT_IRQ_EN:
- Defined: interrupt path as above.
- Undefined: irq_req and irq_en are ignored, irq_ack is tied 0, the IRQ_VEC mux leg is removed, and ports are unchanged.

Decomposition:
- Package fetch_ctrl_pkg:
  - state enum fetch_ctrl_state_e {RUN, FLUSH, HALT}
  - redirect-source enum {SRC_NONE, SRC_TRAP, SRC_BR, SRC_IRQ, SRC_DBG}
  - cause width constant (4)
- One sub-module is natural: redirect_prio_mux. It is combinational and takes the valid bits plus state, producing the selected source and target.
- The FSM, counter and epc register stay in the top module.

Test Plan:
1. Reset released, no requests, stall_req=0 -> clk_en=1 every cycle; write_en=0, flush=0, epc=0.
2. RUN, stall_req=1 and br_valid=1, br_target=15'h1234 in the same cycle -> write_en=1, clk_en=1, data=15'h1234. flush=1 for exactly 2 cycles, then RUN.
3. trap_valid=1, cause=4'h3, br_valid=1, fetch_pc=15'h0100 -> data=15'h0010 and epc=15'h0100 next cycle; branch dropped. A second trap in FLUSH reloads a fresh 2-cycle flush.
4. irq_req=1, irq_en=1, fetch_pc=15'h0200 -> irq_ack one cycle, data=15'h0040, epc=15'h0200. With the macro undefined -> no ack, PC keeps incrementing.
5. halt_req -> halted=1, clk_en=0. dbg_pc_valid with dbg_pc=15'h7FFF -> write_en=1, clk_en=1 for one cycle, still halted. resume_req -> RUN with clk_en=1.
6. async_rst_n asserted mid-FLUSH (flush_cnt=1) -> flush, clk_en and write_en drop to 0 immediately without a clock edge. After release: RUN, epc=0.

Source files
------------

// File: rtl/fetch_redirect_ctrl_pkg.sv
// rtl/fetch_redirect_ctrl_pkg.sv - shared types and constants for the fetch redirect sequencer
package fetch_ctrl_pkg;

    localparam int CAUSE_W = 4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } fetch_ctrl_state_e;

    typedef enum logic [2:0] {
        SRC_NONE = 3'd0,
        SRC_TRAP = 3'd1,
        SRC_BR   = 3'd2,
        SRC_IRQ  = 3'd3,
        SRC_DBG  = 3'd4
    } redirect_src_e;

endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// rtl/fetch_redirect_ctrl_if.sv - request/response bundle between core control and the fetch sequencer
interface fetch_redirect_ctrl_if
    import fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W = 15
);
    logic               stall_req;
    logic               icache_miss;
    logic [ADDR_W-1:0]  fetch_pc;
    logic               br_valid;
    logic [ADDR_W-1:0]  br_target;
    logic               trap_valid;
    logic [CAUSE_W-1:0] trap_cause;
    logic               irq_req;
    logic               irq_en;
    logic               halt_req;
    logic               resume_req;
    logic               dbg_pc_valid;
    logic [ADDR_W-1:0]  dbg_pc;

    logic               fetch_clk_en;
    logic               fetch_write_en;
    logic [ADDR_W-1:0]  fetch_data_in;
    logic               flush;
    logic [ADDR_W-1:0]  epc;
    logic               irq_ack;
    logic               halted;

    modport master (
        output stall_req, icache_miss, fetch_pc, br_valid, br_target,
               trap_valid, trap_cause, irq_req, irq_en, halt_req,
               resume_req, dbg_pc_valid, dbg_pc,
        input  fetch_clk_en, fetch_write_en, fetch_data_in, flush, epc,
               irq_ack, halted
    );

    modport slave (
        input  stall_req, icache_miss, fetch_pc, br_valid, br_target,
               trap_valid, trap_cause, irq_req, irq_en, halt_req,
               resume_req, dbg_pc_valid, dbg_pc,
        output fetch_clk_en, fetch_write_en, fetch_data_in, flush, epc,
               irq_ack, halted
    );

endinterface

// File: rtl/fetch_redirect_ctrl_redirect_prio_mux.sv
// rtl/fetch_redirect_ctrl_redirect_prio_mux.sv - picks the winning redirect source and its target PC
// The interrupt leg exists only when FETCH_REDIRECT_IRQ_EN is defined.
module redirect_prio_mux
    import fetch_ctrl_pkg::*;
#(
    parameter int                ADDR_W   = 15,
    parameter logic [ADDR_W-1:0] TRAP_VEC = 'h0004,
    parameter logic [ADDR_W-1:0] IRQ_VEC  = 'h0040
) (
    input  fetch_ctrl_state_e  i_state,
    input  logic               i_trap_valid,
    input  logic [CAUSE_W-1:0] i_trap_cause,
    input  logic               i_br_valid,
    input  logic [ADDR_W-1:0]  i_br_target,
    input  logic               i_irq_valid,
    input  logic               i_dbg_valid,
    input  logic [ADDR_W-1:0]  i_dbg_pc,
    output redirect_src_e      o_src,
    output logic [ADDR_W-1:0]  o_target
);

    logic [ADDR_W-1:0] w_trap_target;

    // Cause is a word index into the vector table; the sum wraps at ADDR_W.
    assign w_trap_target = TRAP_VEC + ADDR_W'({i_trap_cause, 2'b00});

`ifndef FETCH_REDIRECT_IRQ_EN
    logic [ADDR_W:0] w_unused_irq;
    assign w_unused_irq = {i_irq_valid, IRQ_VEC};
`endif

    always_comb begin
        o_src = SRC_NONE;
        case (i_state)
            RUN: begin
                if (i_trap_valid)
                    o_src = SRC_TRAP;
                else if (i_br_valid)
                    o_src = SRC_BR;
`ifdef FETCH_REDIRECT_IRQ_EN
                else if (i_irq_valid)
                    o_src = SRC_IRQ;
`endif
            end
            FLUSH: begin
                if (i_trap_valid)
                    o_src = SRC_TRAP;
            end
            HALT: begin
                if (i_dbg_valid)
                    o_src = SRC_DBG;
            end
            default: o_src = SRC_NONE;
        endcase
    end

    always_comb begin
        o_target = '0;
        case (o_src)
            SRC_TRAP: o_target = w_trap_target;
            SRC_BR:   o_target = i_br_target;
`ifdef FETCH_REDIRECT_IRQ_EN
            SRC_IRQ:  o_target = IRQ_VEC;
`endif
            SRC_DBG:  o_target = i_dbg_pc;
            default:  o_target = '0;
        endcase
    end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// rtl/fetch_redirect_ctrl.sv - fetch-stage sequencer: PC advance, stall, redirect arbitration and flush
// Optional interrupt redirect path enabled by defining FETCH_REDIRECT_IRQ_EN.
module fetch_redirect_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int                ADDR_W       = 15,
    parameter int                FLUSH_CYCLES = 2,
    parameter logic [ADDR_W-1:0] TRAP_VEC     = 'h0004,
    parameter logic [ADDR_W-1:0] IRQ_VEC      = 'h0040
) (
    input  logic                 clk,
    input  logic                 async_rst_n,
    fetch_redirect_ctrl_if.slave bus
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    fetch_ctrl_state_e r_state;
    fetch_ctrl_state_e w_state_nxt;
    logic [3:0]        r_flush_cnt;
    logic [ADDR_W-1:0] r_epc;

    redirect_src_e     w_src;
    logic [ADDR_W-1:0] w_target;
    logic              w_irq_valid;
    logic              w_redirect;
    logic              w_flush_load;
    logic              w_epc_load;

    logic              w_clk_en;
    logic              w_write_en;
    logic [ADDR_W-1:0] w_data;
    logic              w_flush;
    logic              w_irq_ack;
    logic              w_halted;

    logic              w_unused_miss;
    assign w_unused_miss = bus.icache_miss;

`ifdef FETCH_REDIRECT_IRQ_EN
    assign w_irq_valid = bus.irq_req & bus.irq_en;
`else
    logic w_unused_irq;
    assign w_unused_irq = bus.irq_req | bus.irq_en;
    assign w_irq_valid  = 1'b0;
`endif

    redirect_prio_mux #(
        .ADDR_W   (ADDR_W),
        .TRAP_VEC (TRAP_VEC),
        .IRQ_VEC  (IRQ_VEC)
    ) u_prio_mux (
        .i_state      (r_state),
        .i_trap_valid (bus.trap_valid),
        .i_trap_cause (bus.trap_cause),
        .i_br_valid   (bus.br_valid),
        .i_br_target  (bus.br_target),
        .i_irq_valid  (w_irq_valid),
        .i_dbg_valid  (bus.dbg_pc_valid),
        .i_dbg_pc     (bus.dbg_pc),
        .o_src        (w_src),
        .o_target     (w_target)
    );

    assign w_redirect   = (w_src != SRC_NONE);
    assign w_flush_load = (w_src == SRC_TRAP) || (w_src == SRC_BR) || (w_src == SRC_IRQ);
    assign w_epc_load   = (w_src == SRC_TRAP) || (w_src == SRC_IRQ);

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n)
            r_state <= RUN;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN: begin
                if (w_flush_load)
                    w_state_nxt = FLUSH;
                else if (bus.halt_req)
                    w_state_nxt = HALT;
            end
            FLUSH: begin
                if (w_flush_load)
                    w_state_nxt = FLUSH;
                else if (r_flush_cnt == 4'd0)
                    w_state_nxt = RUN;
            end
            HALT: begin
                if (!bus.dbg_pc_valid && bus.resume_req)
                    w_state_nxt = RUN;
            end
            default: w_state_nxt = RUN;
        endcase
    end

    // Flush length is counted in clocks, not fetch advances, so stall does not stretch it.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            r_flush_cnt <= 4'd0;
            r_epc       <= '0;
        end else begin
            if (w_flush_load)
                r_flush_cnt <= FLUSH_LOAD;
            else if (r_state == FLUSH && r_flush_cnt != 4'd0)
                r_flush_cnt <= r_flush_cnt - 4'd1;
            if (w_epc_load)
                r_epc <= bus.fetch_pc;
        end
    end

    // Outputs are combinational, so they must be forced low while reset is held.
    always_comb begin
        w_clk_en   = 1'b0;
        w_write_en = 1'b0;
        w_data     = '0;
        w_flush    = 1'b0;
        w_irq_ack  = 1'b0;
        w_halted   = 1'b0;
        if (async_rst_n) begin
            w_write_en = w_redirect;
            w_data     = w_redirect ? w_target : '0;
            w_irq_ack  = (w_src == SRC_IRQ);
            case (r_state)
                RUN:     w_clk_en = !bus.halt_req && !bus.stall_req;
                FLUSH: begin
                    w_flush  = 1'b1;
                    w_clk_en = !bus.stall_req;
                end
                HALT:    w_halted = 1'b1;
                default: w_clk_en = 1'b0;
            endcase
            if (w_redirect)
                w_clk_en = 1'b1;
        end
    end

    assign bus.fetch_clk_en   = w_clk_en;
    assign bus.fetch_write_en = w_write_en;
    assign bus.fetch_data_in  = w_data;
    assign bus.flush          = w_flush;
    assign bus.epc            = r_epc;
    assign bus.irq_ack        = w_irq_ack;
    assign bus.halted         = w_halted;

endmodule
